// File: rtl/div_pkg.sv
// Shared types and defaults for the radix-2 sequential divider.
// Holds the controller state encoding, the default operand width and
// a result record sized for the default width.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        POST,
        DONE
    } div_state_e;

    // Result record at the default width, for consumers that bundle the
    // divider outputs.
    typedef struct packed {
        logic [DIV_WIDTH-1:0] quo;
        logic [DIV_WIDTH-1:0] rem;
        logic                 dbz;
    } div_res_t;

endpackage

// File: rtl/div_01bit_step.sv
// One restoring-division step: shift the next dividend bit into the partial remainder, trial-subtract the divisor.
// Latency: purely combinational, zero cycles.
// Backpressure: none, it has no handshake and is evaluated every cycle.
//
// Ports:
//   rem_in  - partial remainder before this step (always < divisor for b != 0)
//   dvd_bit - dividend bit entering the remainder LSB
//   divisor - divisor magnitude
//   rem_out - partial remainder after this step
//   q_bit   - quotient bit retired by this step
module div_01bit_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           unused_shift_msb;

    assign shifted = {rem_in, dvd_bit};
    assign trial   = shifted - {1'b0, divisor};

    // rem_in < divisor keeps shifted below 2*divisor, so a WIDTH+1-bit
    // difference has its MSB set exactly when the subtraction borrowed.
    assign q_bit   = ~trial[WIDTH];

    // A restored remainder is below the divisor, so it fits in WIDTH bits.
    assign rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

    assign unused_shift_msb = shifted[WIDTH];

endmodule

// File: rtl/div_radix2_seq.sv
// Iterative radix-2 restoring divider (DIV/REM) retiring one quotient bit per clock.
// Latency: o_valid rises WIDTH+2 edges after the accepting edge, independent of the data.
// Backpressure: o_ready is high only in IDLE; the result is held in DONE until i_ready.
//
// Ports: i_clk/i_rst_n (async active-low), i_valid/o_ready request handshake with
// i_sig, i_num_a (dividend), i_num_b (divisor); o_valid/i_ready result handshake
// with o_quo, o_rem, o_dbz (divide-by-zero, qualified by o_valid).
// Build option: define DIV_SIGNED_EN to honour i_sig (two's-complement, quotient
// truncates toward zero, remainder takes the dividend's sign). Without it every
// operation is unsigned and i_sig is ignored; PREP/POST still take one cycle each.
module div_radix2_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_sig,
    input  logic [WIDTH-1:0] i_num_a,
    input  logic [WIDTH-1:0] i_num_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_quo,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_dbz
);

    div_state_e       state_q;
    div_state_e       state_d;

    logic [WIDTH-1:0] a_q;     // original dividend, returned as remainder on divide-by-zero
    logic [WIDTH-1:0] b_q;     // raw divisor until PREP, then its magnitude
    logic [WIDTH-1:0] dvd_q;   // dividend bits shift out the top, quotient bits shift in
    logic [WIDTH-1:0] rem_q;   // partial remainder
    logic [CNT_W-1:0] cnt_q;
    logic             dbz_q;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] quo_fin;
    logic [WIDTH-1:0] rem_fin;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;

`ifdef DIV_SIGNED_EN
    logic sig_q;
    logic quo_neg_q;
    logic rem_neg_q;
    logic sa;
    logic sb;

    assign sa      = sig_q & a_q[WIDTH-1];
    assign sb      = sig_q & b_q[WIDTH-1];
    // Negating MIN yields MIN, which reads correctly as an unsigned magnitude,
    // so MIN / -1 lands on quotient MIN, remainder 0 without a special case.
    assign mag_a   = sa ? -a_q : a_q;
    assign mag_b   = sb ? -b_q : b_q;
    assign quo_fin = quo_neg_q ? -dvd_q : dvd_q;
    assign rem_fin = rem_neg_q ? -rem_q : rem_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sig_q     <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else begin
            if (state_q == IDLE && i_valid) begin
                sig_q <= i_sig;
            end
            if (state_q == PREP) begin
                quo_neg_q <= sa ^ sb;
                rem_neg_q <= sa;
            end
        end
    end
`else
    logic unused_sig;

    assign unused_sig = i_sig;
    assign mag_a      = a_q;
    assign mag_b      = b_q;
    assign quo_fin    = dvd_q;
    assign rem_fin    = rem_q;
`endif

    // Single step instance, reused for every CALC iteration.
    div_01bit_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem_q),
        .dvd_bit (dvd_q[WIDTH-1]),
        .divisor (b_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        o_ready = 1'b0;
        o_valid = 1'b0;
        case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    state_d = PREP;
                end
            end
            PREP: state_d = CALC;
            CALC: begin
                if (cnt_q == '0) begin
                    state_d = POST;
                end
            end
            POST: state_d = DONE;
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            dvd_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
            dbz_q <= 1'b0;
            o_quo <= '0;
            o_rem <= '0;
            o_dbz <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        a_q <= i_num_a;
                        b_q <= i_num_b;
                    end
                end
                PREP: begin
                    dvd_q <= mag_a;
                    b_q   <= mag_b;
                    rem_q <= '0;
                    dbz_q <= (b_q == '0);
                    cnt_q <= CNT_W'(WIDTH - 1);
                end
                CALC: begin
                    rem_q <= step_rem;
                    dvd_q <= {dvd_q[WIDTH-2:0], step_q};
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                POST: begin
                    o_dbz <= dbz_q;
                    if (dbz_q) begin
                        o_quo <= '1;
                        o_rem <= a_q;
                    end else begin
                        o_quo <= quo_fin;
                        o_rem <= rem_fin;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_radix2_seq.sv
module tb_div_radix2_seq;

    localparam int W       = 32;
    localparam int LATENCY = W + 2;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sig;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic         i_valid;
    logic         o_ready;
    logic         i_sig;
    logic [W-1:0] i_num_a;
    logic [W-1:0] i_num_b;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_quo;
    logic [W-1:0] o_rem;
    logic         o_dbz;

    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];
    exp_t sb_q[$];

    div_radix2_seq #(.WIDTH(W)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_sig   (i_sig),
        .i_num_a (i_num_a),
        .i_num_b (i_num_b),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_quo   (o_quo),
        .o_rem   (o_rem),
        .o_dbz   (o_dbz)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [W-1:0] a, input logic [W-1:0] b, input logic sig,
                       input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz);
        vec_t v;
        v.a = a; v.b = b; v.sig = sig; v.q = q; v.r = r; v.dbz = dbz;
        vecs.push_back(v);
    endtask

    // Scoreboard consumer: a result is taken on every output handshake.
    always @(negedge i_clk) begin
        if (i_rst_n && o_valid && i_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got result %h/%h with no request pending", o_quo, o_rem);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("quo", o_quo, e.q);
                chk("rem", o_rem, e.r);
                chk("dbz", W'(o_dbz), W'(e.dbz));
            end
        end
    end

    // One request through the divider; hold > 0 withholds i_ready for that many
    // cycles after o_valid while offering a competing request.
    task automatic do_op(input vec_t v, input int hold);
        exp_t e;
        int   n;
        bit   seen;
        @(posedge i_clk); #1;
        i_valid = 1'b1;
        i_num_a = v.a;
        i_num_b = v.b;
        i_sig   = v.sig;
        i_ready = (hold == 0);
        chk("ready_idle", W'(o_ready), W'(1));
        e.q = v.q; e.r = v.r; e.dbz = v.dbz;
        sb_q.push_back(e);
        @(posedge i_clk); #1;
        // Busy-time input changes must not disturb the operation.
        i_valid = 1'b0;
        i_num_a = $urandom;
        i_num_b = $urandom;
        i_sig   = 1'($urandom);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(posedge i_clk);
            n++;
            @(negedge i_clk);
            seen = o_valid;
            if (!seen) chk("ready_busy", W'(o_ready), W'(0));
        end
        chk("latency", W'(n), W'(LATENCY));
        if (!seen) return;
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge i_clk); #1;
                i_valid = 1'b1;
                i_num_a = 32'd5;
                i_num_b = 32'd1;
                @(negedge i_clk);
                chk("hold_valid", W'(o_valid), W'(1));
                chk("hold_ready", W'(o_ready), W'(0));
                chk("hold_quo", o_quo, v.q);
            end
            @(posedge i_clk); #1;
            i_valid = 1'b0;
            i_ready = 1'b1;
            @(negedge i_clk);
        end
        @(negedge i_clk);
        chk("post_valid", W'(o_valid), W'(0));
        chk("post_ready", W'(o_ready), W'(1));
    endtask

    initial begin
        vec_t v;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_sig   = 1'b0;
        i_num_a = '0;
        i_num_b = '0;
        i_ready = 1'b1;

        add(32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0);
        add(32'h0000_1234,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h0000_1234,  1'b1);
        add(32'hFFFF_FFFF,  32'h10,         1'b0, 32'h0FFF_FFFF,  32'hF,          1'b0);
        add(32'd0,          32'd5,          1'b0, 32'd0,          32'd0,          1'b0);
        add(32'd5,          32'd5,          1'b0, 32'd1,          32'd0,          1'b0);
        add(32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0);
        add(32'hFFFF_FFFF,  32'hFFFF_FFFE,  1'b0, 32'd1,          32'd1,          1'b0);
        add(32'd12345678,   32'd1000,       1'b0, 32'd12345,      32'd678,        1'b0);
`ifdef DIV_SIGNED_EN
        add(32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0);
        add(32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0);
        add(32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0);
        add(32'hFFFF_FFFB,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1);
        add(32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1,          1'b0);
`else
        // i_sig is ignored: these produce the unsigned results.
        add(32'hFFFF_FFF9,  32'd2,          1'b1, 32'h7FFF_FFFC,  32'd1,          1'b0);
        add(32'd7,          32'hFFFF_FFFE,  1'b1, 32'd0,          32'd7,          1'b0);
        add(32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'd0,          32'h8000_0000,  1'b0);
`endif

        #2;
        chk("rst_ready", W'(o_ready), W'(1));
        chk("rst_valid", W'(o_valid), W'(0));
        chk("rst_quo",   o_quo,       W'(0));
        chk("rst_rem",   o_rem,       W'(0));
        chk("rst_dbz",   W'(o_dbz),   W'(0));
        repeat (3) @(posedge i_clk);
        #1 i_rst_n = 1'b1;

        foreach (vecs[i]) do_op(vecs[i], 0);

        // Backpressure: result held for 10 cycles, competing request refused.
        add(32'd1000, 32'd33, 1'b0, 32'd30, 32'd10, 1'b0);
        do_op(vecs[vecs.size()-1], 10);

        // Reset during CALC aborts the operation without a result.
        @(posedge i_clk); #1;
        i_valid = 1'b1;
        i_num_a = 32'h1234_5678;
        i_num_b = 32'd3;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (16) @(posedge i_clk);
        #1 i_rst_n = 1'b0;
        #1;
        chk("abort_ready", W'(o_ready), W'(1));
        chk("abort_valid", W'(o_valid), W'(0));
        chk("abort_quo",   o_quo,       W'(0));
        chk("abort_rem",   o_rem,       W'(0));
        chk("abort_dbz",   W'(o_dbz),   W'(0));
        @(posedge i_clk); #1 i_rst_n = 1'b1;
        v.a = 32'hFFFF_FFFF; v.b = 32'h10; v.sig = 1'b0;
        v.q = 32'h0FFF_FFFF; v.r = 32'hF;  v.dbz = 1'b0;
        do_op(v, 0);

        repeat (2) @(negedge i_clk);
        chk("sb_empty", W'(sb_q.size()), W'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
